// File: rtl/bus2reg_pkg.sv
// bus2reg_pkg: shared state type, default widths and sizing helper for the Bus2Reg arbiter
package bus2reg_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 15;

    // Counter width able to hold 0..timeout; a disabled timeout still needs one bit
    function automatic int tmo_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: picks the first requester at or after ptr, wrapping around
module rr_picker
    import bus2reg_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] src;

    // Prefer requesters at or above ptr, otherwise wrap to the lowest; isolate the lowest set bit
    always_comb begin
        upper = req & ({NUM_REQ{1'b1}} << ptr);
        src   = (|upper) ? upper : req;
        pick  = src & (-src);
        valid = |req;
    end

endmodule

// File: rtl/bus2reg_arbiter.sv
// bus2reg_arbiter: round-robin sharing of one Bus2Reg register bus among several front-ends
module bus2reg_arbiter
    import bus2reg_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              s_bus_req,
    input  logic [NUM_REQ-1:0]              s_bus_req_is_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_bus_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_bus_wr_data,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_bus_wr_biten,
    output logic [NUM_REQ-1:0]              s_bus_ready,
    output logic [NUM_REQ-1:0]              s_bus_err,
    output logic [DATA_WIDTH-1:0]           s_bus_rd_data,
    output logic                            m_bus_req,
    output logic                            m_bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]           m_bus_addr,
    output logic [DATA_WIDTH-1:0]           m_bus_wr_data,
    output logic [DATA_WIDTH/8-1:0]         m_bus_wr_biten,
    input  logic                            m_bus_ready,
    input  logic                            m_bus_err,
    input  logic [DATA_WIDTH-1:0]           m_bus_rd_data,
    output logic [NUM_REQ-1:0]              grant
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TW    = tmo_width(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = '1;

    arb_state_t          state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [TW-1:0]       tmo_cnt;
    logic                lat_is_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wr_data;
    logic [BE_W-1:0]     lat_biten;

    logic                busy;
    logic                tmo_hit;
    logic                done;
    logic [PTR_W-1:0]    g_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic [PTR_W-1:0]    pick_ptr;
    logic [NUM_REQ-1:0]  pick_req;
    logic [NUM_REQ-1:0]  pick;
    logic                pick_valid;
    logic                sel_is_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wr_data;
    logic [BE_W-1:0]     sel_biten;

    // Completion happens on register-block ready, or when the wait budget runs out
    always_comb begin
        busy    = (state == BUSY);
        tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
        done    = busy && (m_bus_ready || tmo_hit);
    end

    // On completion the owner's request is stale, so mask it and search from just past it
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) g_idx = PTR_W'(i);
        next_ptr = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
        pick_req = s_bus_req & ~(done ? grant : '0);
        pick_ptr = done ? next_ptr : rr_ptr;
    end

    rr_picker #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) u_picker (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .pick (pick),
        .valid(pick_valid)
    );

    // Select the picked requester's command fields from the packed input buses
    always_comb begin
        sel_is_wr   = |(s_bus_req_is_wr & pick);
        sel_addr    = '0;
        sel_wr_data = '0;
        sel_biten   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                sel_addr    = s_bus_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wr_data = s_bus_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_biten   = s_bus_wr_biten[i*BE_W +: BE_W];
            end
        end
    end

    // Drive the register bus from latched fields and route the response to the owner only
    always_comb begin
        m_bus_req       = busy;
        m_bus_req_is_wr = busy && lat_is_wr;
        m_bus_addr      = busy ? lat_addr : '0;
        m_bus_wr_data   = busy ? lat_wr_data : '0;
        m_bus_wr_biten  = (busy && lat_is_wr) ? lat_biten : '0;
        s_bus_ready     = done ? grant : '0;
        s_bus_err       = done ? (grant & {NUM_REQ{~m_bus_ready | m_bus_err}}) : '0;
        s_bus_rd_data   = (busy && m_bus_ready) ? m_bus_rd_data : '0;
    end

    // Grant/latch on entry or back-to-back after completion; otherwise count wait cycles without wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            tmo_cnt     <= '0;
            lat_is_wr   <= 1'b0;
            lat_addr    <= '0;
            lat_wr_data <= '0;
            lat_biten   <= '0;
        end else begin
            if (done) rr_ptr <= next_ptr;
            if (!busy || done) begin
                state   <= pick_valid ? BUSY : IDLE;
                grant   <= pick;
                tmo_cnt <= '0;
                if (pick_valid) begin
                    lat_is_wr   <= sel_is_wr;
                    lat_addr    <= sel_addr;
                    lat_wr_data <= sel_wr_data;
                    lat_biten   <= sel_biten;
                end
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus2reg_arbiter.sv
// tb_bus2reg_arbiter: random requesters and register block checked against a transaction-level model
module tb_bus2reg_arbiter;

    localparam int N   = 2;
    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    s_bus_req = '0;
    logic [N-1:0]    s_bus_req_is_wr = '0;
    logic [N*AW-1:0] s_bus_addr = '0;
    logic [N*DW-1:0] s_bus_wr_data = '0;
    logic [N*BW-1:0] s_bus_wr_biten = '0;
    logic [N-1:0]    s_bus_ready;
    logic [N-1:0]    s_bus_err;
    logic [DW-1:0]   s_bus_rd_data;
    logic            m_bus_req;
    logic            m_bus_req_is_wr;
    logic [AW-1:0]   m_bus_addr;
    logic [DW-1:0]   m_bus_wr_data;
    logic [BW-1:0]   m_bus_wr_biten;
    logic            m_bus_ready = 1'b0;
    logic            m_bus_err = 1'b0;
    logic [DW-1:0]   m_bus_rd_data = '0;
    logic [N-1:0]    grant;

    bus2reg_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_bus_req(s_bus_req), .s_bus_req_is_wr(s_bus_req_is_wr),
        .s_bus_addr(s_bus_addr), .s_bus_wr_data(s_bus_wr_data),
        .s_bus_wr_biten(s_bus_wr_biten),
        .s_bus_ready(s_bus_ready), .s_bus_err(s_bus_err), .s_bus_rd_data(s_bus_rd_data),
        .m_bus_req(m_bus_req), .m_bus_req_is_wr(m_bus_req_is_wr),
        .m_bus_addr(m_bus_addr), .m_bus_wr_data(m_bus_wr_data),
        .m_bus_wr_biten(m_bus_wr_biten),
        .m_bus_ready(m_bus_ready), .m_bus_err(m_bus_err), .m_bus_rd_data(m_bus_rd_data),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: current owner (-1 = none), round-robin start index, busy cycles elapsed
    int owner = -1;
    int ptr   = 0;
    int cnt   = 0;
    logic          mdl_is_wr = 1'b0;
    logic [AW-1:0] mdl_addr  = '0;
    logic [DW-1:0] mdl_data  = '0;
    logic [BW-1:0] mdl_be    = '0;
    logic [N-1:0]  pend      = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic int pick_model(input logic [N-1:0] r, input int p, input int m);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                if (j == (p + k) % N && r[j] && j != m) return j;
        return -1;
    endfunction

    task automatic set_txn(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        pend[i] = 1'b1;
        s_bus_req_is_wr[i]      = wr;
        s_bus_addr[i*AW +: AW]  = a;
        s_bus_wr_data[i*DW +: DW] = d;
        s_bus_wr_biten[i*BW +: BW] = be;
    endtask

    task automatic rand_txn(input int i);
        set_txn(i, 1'($urandom_range(1)), AW'($urandom), $urandom, BW'($urandom));
    endtask

    // Random requesters hold their command until completion; the owner may scramble
    // its inputs or drop req, which a latched arbiter must ignore
    task automatic drive(input int req_pct, input int rdy_pct);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(99) < req_pct) rand_txn(i);
            else if (pend[i] && owner == i && $urandom_range(9) == 0) begin
                rand_txn(i);
            end
            s_bus_req[i] = pend[i] && !(owner == i && $urandom_range(7) == 0);
        end
        m_bus_ready   = ($urandom_range(99) < rdy_pct);
        if (rdy_pct == 0 && owner >= 0 && cnt == TMO - 1) m_bus_ready = 1'($urandom_range(1));
        m_bus_err     = ($urandom_range(3) == 0);
        m_bus_rd_data = $urandom;
    endtask

    // Check outputs against the model for the current inputs, then advance one clock
    task automatic step();
        logic          busy, e_done, e_norm, e_errbit;
        logic [N-1:0]  g;
        int            nx, mask, done_owner;
        #1;
        busy     = rst && owner >= 0;
        e_done   = busy && (m_bus_ready || (TMO != 0 && cnt == TMO - 1));
        e_norm   = e_done && m_bus_ready;
        e_errbit = m_bus_ready ? m_bus_err : 1'b1;
        for (int i = 0; i < N; i++) g[i] = busy && owner == i;
        check("grant",      64'(grant),           64'(g));
        check("m_req",      64'(m_bus_req),       64'(busy));
        check("m_is_wr",    64'(m_bus_req_is_wr), 64'(busy && mdl_is_wr));
        check("m_addr",     64'(m_bus_addr),      busy ? 64'(mdl_addr) : 64'(0));
        check("m_wr_data",  64'(m_bus_wr_data),   busy ? 64'(mdl_data) : 64'(0));
        check("m_biten",    64'(m_bus_wr_biten),  (busy && mdl_is_wr) ? 64'(mdl_be) : 64'(0));
        check("s_ready",    64'(s_bus_ready),     e_done ? 64'(g) : 64'(0));
        check("s_err",      64'(s_bus_err),       (e_done && e_errbit) ? 64'(g) : 64'(0));
        check("s_rd_data",  64'(s_bus_rd_data),   e_norm ? 64'(m_bus_rd_data) : 64'(0));
        @(posedge clk);
        done_owner = -1;
        if (!rst) begin
            owner = -1;
            ptr   = 0;
            cnt   = 0;
        end else if (owner < 0 || e_done) begin
            mask = -1;
            if (e_done) begin
                ptr        = (owner + 1) % N;
                mask       = owner;
                done_owner = owner;
            end
            nx    = pick_model(s_bus_req, ptr, mask);
            owner = nx;
            cnt   = 0;
            if (nx >= 0) begin
                mdl_is_wr = s_bus_req_is_wr[nx];
                mdl_addr  = s_bus_addr[nx*AW +: AW];
                mdl_data  = s_bus_wr_data[nx*DW +: DW];
                mdl_be    = s_bus_wr_biten[nx*BW +: BW];
            end
        end else begin
            cnt++;
        end
        if (done_owner >= 0) pend[done_owner] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int req_tab[3];
        int rdy_tab[4];
        req_tab = '{20, 60, 100};
        rdy_tab = '{100, 50, 10, 0};
        @(negedge clk);
        step();
        rst = 1'b1;
        // Single write with the register block always ready
        set_txn(0, 1'b1, 3'd3, 32'hDEAD_BEEF, 4'hF);
        m_bus_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_bus_req = pend;
            step();
        end
        // Read with three wait states
        set_txn(1, 1'b0, 3'd5, 32'h0, 4'hF);
        m_bus_rd_data = 32'h1234;
        for (int k = 0; k < 6; k++) begin
            s_bus_req   = pend;
            m_bus_ready = (k == 4);
            step();
        end
        // Contention with both requesters continuously active, register block always ready
        for (int k = 0; k < 10; k++) begin
            drive(100, 100);
            step();
        end
        // Timeouts, with an occasional ready landing on the last wait cycle
        for (int k = 0; k < 120; k++) begin
            drive(30, 0);
            step();
        end
        // Error passthrough: every completion carries m_bus_err
        for (int k = 0; k < 20; k++) begin
            drive(100, 70);
            m_bus_err = 1'b1;
            step();
        end
        // Random mix of load and register block latency
        for (int p = 0; p < 12; p++) begin
            for (int k = 0; k < 120; k++) begin
                drive(req_tab[p % 3], rdy_tab[p % 4]);
                step();
            end
        end
        // Reset during a wait state, then requester 1 alone must win from pointer 0
        for (int k = 0; k < 40 && !(owner >= 0 && cnt > 1); k++) begin
            drive(100, 0);
            step();
        end
        rst = 1'b0;
        step();
        step();
        pend      = '0;
        set_txn(1, 1'b1, 3'd6, 32'hCAFE_0001, 4'h3);
        s_bus_req = pend;
        m_bus_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("post_rst_grant", 64'(grant), 64'(2'b10));
        for (int k = 0; k < 200; k++) begin
            drive(60, 40);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
